// File: rtl/parity_pkg.sv
// Shared constants for the parity stream generator: parity mode encodings,
// frame FSM state encodings and the clog2 helper used to size frame_len.
package parity_pkg;

   localparam logic PAR_MODE_EVEN = 1'b0;
   localparam logic PAR_MODE_ODD  = 1'b1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int f_clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational word parity: XOR reduction of data, inverted in odd mode so
// that ones(data) + par is odd in odd mode and even in even mode.
module parity_calc #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              mode_odd,
   output logic              par
);

   assign par = (^data) ^ mode_odd;

endmodule

// File: rtl/parity_stream_gen.sv
// Streaming parity generator: registers each accepted word with its parity
// bit and accumulates parity over a frame closed by in_last or by reaching
// FRAME_MAX beats. Optional input parity checking is built when the macro
// PARITY_GEN_CHECK_EN is defined (adds in_par, par_err, err_sticky).
module parity_stream_gen
   import parity_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int FRAME_MAX = 16,
   parameter int CNT_W     = f_clog2(FRAME_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode_odd,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par,
   output logic              out_last,
   output logic              frame_valid,
   output logic              frame_par,
   output logic [CNT_W-1:0]  frame_len
`ifdef PARITY_GEN_CHECK_EN
   ,
   input  logic              in_par,
   output logic              par_err,
   output logic              err_sticky
`endif
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(FRAME_MAX);

   logic [0:0]        r_state;
   logic [CNT_W-1:0]  r_count;
   logic              r_acc;

   logic              r_out_valid_p1;
   logic [DATA_W-1:0] r_out_data_p1;
   logic              r_out_par_p1;
   logic              r_out_last_p1;
   logic              r_frame_valid_p1;
   logic              r_frame_par_p1;
   logic [CNT_W-1:0]  r_frame_len_p1;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_par;
   logic              w_red;
   logic [CNT_W-1:0]  w_count_next;
   logic              w_acc_next;
   logic              w_close;

   parity_calc #(.DATA_W(DATA_W)) u_calc (
      .data     (in_data),
      .mode_odd (mode_odd),
      .par      (w_par)
   );

   // Handshake: no skid buffer, so the stage accepts whenever it is empty or draining.
   assign w_in_ready = !rst && (!r_out_valid_p1 || out_ready);
   assign w_accept   = in_valid && w_in_ready;

   // Next frame count / accumulator and the frame close decision for this beat.
   always_comb begin
      // Undo the mode inversion to recover the raw XOR reduction of the word.
      w_red = w_par ^ mode_odd;
      if (r_state == ST_IDLE) begin
         w_count_next = CNT_W'(1);
         w_acc_next   = w_red;
      end else begin
         w_count_next = r_count + CNT_W'(1);
         w_acc_next   = r_acc ^ w_red;
      end
      w_close = w_accept && (in_last || (w_count_next == MAX_CNT));
   end

   // Frame FSM: opens on the first accept, closes on in_last or FRAME_MAX beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_acc   <= 1'b0;
      end else if (w_accept) begin
         if (w_close) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_acc   <= 1'b0;
         end else begin
            r_state <= ST_ACCUM;
            r_count <= w_count_next;
            r_acc   <= w_acc_next;
         end
      end
   end

   // ---- stage p1: registered word, parity and frame report ----
   // Output word register; holds under backpressure, drains on out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid_p1 <= 1'b0;
         r_out_data_p1  <= '0;
         r_out_par_p1   <= 1'b0;
         r_out_last_p1  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid_p1 <= 1'b1;
         r_out_data_p1  <= in_data;
         r_out_par_p1   <= w_par;
         r_out_last_p1  <= w_close;
      end else if (out_ready) begin
         r_out_valid_p1 <= 1'b0;
      end
   end

   // Frame report: single-cycle pulse on close; parity and length hold between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_valid_p1 <= 1'b0;
         r_frame_par_p1   <= 1'b0;
         r_frame_len_p1   <= '0;
      end else begin
         r_frame_valid_p1 <= w_close;
         if (w_close) begin
            r_frame_par_p1 <= w_acc_next ^ mode_odd;
            r_frame_len_p1 <= w_count_next;
         end
      end
   end

`ifdef PARITY_GEN_CHECK_EN
   logic r_par_err_p1;
   logic r_err_sticky;

   // Received-parity check, registered alongside the word; sticky flag until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_par_err_p1 <= 1'b0;
         r_err_sticky <= 1'b0;
      end else if (w_accept) begin
         r_par_err_p1 <= (in_par != w_par);
         r_err_sticky <= r_err_sticky | (in_par != w_par);
      end
   end

   assign par_err    = r_par_err_p1;
   assign err_sticky = r_err_sticky;
`endif

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid_p1;
   assign out_data    = r_out_data_p1;
   assign out_par     = r_out_par_p1;
   assign out_last    = r_out_last_p1;
   assign frame_valid = r_frame_valid_p1;
   assign frame_par   = r_frame_par_p1;
   assign frame_len   = r_frame_len_p1;

endmodule

// File: tb/tb_parity_stream_gen.sv
// Testbench for parity_stream_gen (DATA_W=8, FRAME_MAX=4). Directed scenarios
// followed by randomized traffic, checked against a ones-counting reference
// model. Define PARITY_GEN_CHECK_EN to also exercise in_par/par_err/err_sticky.
module tb_parity_stream_gen;
   import parity_pkg::*;

   localparam int DATA_W    = 8;
   localparam int FRAME_MAX = 4;
   localparam int CNT_W     = f_clog2(FRAME_MAX + 1);

   logic              clk;
   logic              rst;
   logic              mode_odd;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_par;
   logic              out_last;
   logic              frame_valid;
   logic              frame_par;
   logic [CNT_W-1:0]  frame_len;
   logic              in_par;
`ifdef PARITY_GEN_CHECK_EN
   logic              par_err;
   logic              err_sticky;
`endif

   parity_stream_gen #(.DATA_W(DATA_W), .FRAME_MAX(FRAME_MAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .mode_odd    (mode_odd),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_par     (out_par),
      .out_last    (out_last),
      .frame_valid (frame_valid),
      .frame_par   (frame_par),
      .frame_len   (frame_len)
`ifdef PARITY_GEN_CHECK_EN
      ,
      .in_par      (in_par),
      .par_err     (par_err),
      .err_sticky  (err_sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Reference model state: what the sink and frame monitor should observe.
   logic              m_ov;
   logic [DATA_W-1:0] m_od;
   logic              m_op;
   logic              m_ol;
   logic              m_fv;
   logic              m_fp;
   int                m_fl;
   int                m_cnt;
   int                m_ones;
   logic              m_perr;
   logic              m_sticky;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Parity bit making (k + par) odd in odd mode, even in even mode.
   function automatic logic par_for(input int k, input logic m);
      return (m == PAR_MODE_ODD) ? ((k % 2) == 0) : ((k % 2) == 1);
   endfunction

   task automatic model_reset();
      m_ov = 0; m_od = '0; m_op = 0; m_ol = 0;
      m_fv = 0; m_fp = 0; m_fl = 0;
      m_cnt = 0; m_ones = 0; m_perr = 0; m_sticky = 0;
   endtask

   // One clock: check in_ready before the edge, advance model, check outputs after.
   task automatic step();
      logic exp_ready;
      logic close;
      logic wp;
      int   k;
      #1;
      exp_ready = !rst && (!m_ov || out_ready);
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         m_fv = 0;
         if (in_valid && exp_ready) begin
            k      = $countones(in_data);
            wp     = par_for(k, mode_odd);
            m_cnt  = m_cnt + 1;
            m_ones = m_ones + k;
            close  = in_last || (m_cnt == FRAME_MAX);
            m_ov = 1; m_od = in_data; m_op = wp; m_ol = close;
            m_perr   = (in_par != wp);
            m_sticky = m_sticky | m_perr;
            if (close) begin
               m_fv = 1;
               m_fp = par_for(m_ones, mode_odd);
               m_fl = m_cnt;
               m_cnt = 0;
               m_ones = 0;
            end
         end else if (out_ready) begin
            m_ov = 0;
         end
      end
      chk("out_valid",   {31'b0, out_valid},   {31'b0, m_ov});
      chk("out_data",    {24'b0, out_data},    {24'b0, m_od});
      chk("out_par",     {31'b0, out_par},     {31'b0, m_op});
      chk("out_last",    {31'b0, out_last},    {31'b0, m_ol});
      chk("frame_valid", {31'b0, frame_valid}, {31'b0, m_fv});
      chk("frame_par",   {31'b0, frame_par},   {31'b0, m_fp});
      chk("frame_len",   32'(frame_len),       32'(m_fl));
`ifdef PARITY_GEN_CHECK_EN
      chk("par_err",     {31'b0, par_err},     {31'b0, m_perr});
      chk("err_sticky",  {31'b0, err_sticky},  {31'b0, m_sticky});
`endif
   endtask

   task automatic beat(input logic [DATA_W-1:0] d, input logic m, input logic last);
      in_valid = 1; in_data = d; mode_odd = m; in_last = last;
      step();
   endtask

   logic [15:0] sweep_exp;
   logic [2:0]  even_exp;

   initial begin
      model_reset();
      rst = 1; mode_odd = 0; in_valid = 0; in_data = '0; in_last = 0;
      out_ready = 1; in_par = 0;

      // Reset state
      step();
      step();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      rst = 0;
      in_valid = 0;
      step();

      // 4-bit exhaustive sweep, odd mode, single-beat frames
      sweep_exp = 16'b1001_0110_0110_1001;
      for (int i = 0; i < 16; i++) begin
         in_par = par_for($countones(i), PAR_MODE_ODD);
         beat(DATA_W'(i), PAR_MODE_ODD, 1'b1);
         chk("sweep_par", {31'b0, out_par}, {31'b0, sweep_exp[i]});
         chk("sweep_len", 32'(frame_len), 32'd1);
      end

      // Even-mode frame 0x01, 0x03, 0x07
      even_exp = 3'b101;
      beat(8'h01, PAR_MODE_EVEN, 1'b0);
      chk("even_par0", {31'b0, out_par}, {31'b0, even_exp[0]});
      beat(8'h03, PAR_MODE_EVEN, 1'b0);
      chk("even_par1", {31'b0, out_par}, {31'b0, even_exp[1]});
      chk("even_nofv", {31'b0, frame_valid}, 32'd0);
      beat(8'h07, PAR_MODE_EVEN, 1'b1);
      chk("even_par2", {31'b0, out_par}, {31'b0, even_exp[2]});
      chk("even_fv", {31'b0, frame_valid}, 32'd1);
      chk("even_fpar", {31'b0, frame_par}, 32'd0);
      chk("even_flen", 32'(frame_len), 32'd3);

      // Forced close after FRAME_MAX beats of 0x01
      for (int i = 1; i <= 6; i++) begin
         beat(8'h01, PAR_MODE_ODD, 1'b0);
         if (i == 4) begin
            chk("force_last", {31'b0, out_last}, 32'd1);
            chk("force_fv", {31'b0, frame_valid}, 32'd1);
            chk("force_flen", 32'(frame_len), 32'd4);
            chk("force_fpar", {31'b0, frame_par}, 32'd1);
         end
      end
      beat(8'h01, PAR_MODE_ODD, 1'b1);
      chk("force_second_len", 32'(frame_len), 32'd3);

      // Backpressure: sink stalls for 3 cycles with source valid held
      beat(8'hA5, PAR_MODE_ODD, 1'b0);
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         beat(DATA_W'(8'h10 + i), PAR_MODE_ODD, 1'b0);
         chk("bp_hold", {24'b0, out_data}, 32'h0000_00A5);
      end
      out_ready = 1;
      beat(8'h3C, PAR_MODE_ODD, 1'b1);
      chk("bp_release", {24'b0, out_data}, 32'h0000_003C);
      in_valid = 0;
      step();

      // Reset mid-frame discards the partial frame
      beat(8'hFF, PAR_MODE_EVEN, 1'b0);
      beat(8'h0F, PAR_MODE_EVEN, 1'b0);
      rst = 1; in_valid = 0;
      step();
      chk("midrst_fv", {31'b0, frame_valid}, 32'd0);
      chk("midrst_ov", {31'b0, out_valid}, 32'd0);
      rst = 0;
      beat(8'h81, PAR_MODE_ODD, 1'b1);
      chk("midrst_len", 32'(frame_len), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_last   = ($urandom_range(0, 4) == 0);
         mode_odd  = 1'($urandom);
         in_data   = DATA_W'($urandom);
         in_par    = ($urandom_range(0, 7) == 0) ? 1'($urandom) : par_for($countones(in_data), mode_odd);
         step();
      end

      // Received-parity check: 0x0F in odd mode computes parity 1
      rst = 1; in_valid = 0; out_ready = 1;
      step();
      rst = 0;
      in_par = 1;
      beat(8'h0F, PAR_MODE_ODD, 1'b1);
      in_par = 0;
      beat(8'h0F, PAR_MODE_ODD, 1'b1);
      in_par = 0;
      beat(8'h01, PAR_MODE_ODD, 1'b1);
`ifdef PARITY_GEN_CHECK_EN
      chk("chk_sticky_hold", {31'b0, err_sticky}, 32'd1);
      chk("chk_err_clear", {31'b0, par_err}, 32'd0);
`endif
      rst = 1; in_valid = 0;
      step();
      rst = 0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
